// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: drives a synchronous instruction memory and buffers
// {npc, instr} pairs in a prefetch queue behind a valid/ready IF/ID handshake.
module fetch_queue_stage #(
   parameter int unsigned    AW       = 32,
   parameter int unsigned    DW       = 32,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [AW-1:0]  RESET_PC = '0,
   parameter int unsigned    CW       = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ex_mem_pc_src,
   input  logic [AW-1:0] ex_mem_npc,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic [DW-1:0] imem_rdata,
   output logic          if_id_valid,
   input  logic          if_id_ready,
   output logic [DW-1:0] if_id_instr,
   output logic [AW-1:0] if_id_npc,
   output logic [CW-1:0] redirect_cnt
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [AW-1:0] pc;
   logic [AW-1:0] tag_npc;
   logic          inflight;
   logic [PW:0]   count;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [DW-1:0] q_instr [DEPTH];
   logic [AW-1:0] q_npc   [DEPTH];

   logic          pop;
   logic          push;
   logic [PW+1:0] occupancy;

   assign if_id_valid = (count != '0);
   assign pop         = if_id_valid & if_id_ready;
   assign push        = inflight & ~ex_mem_pc_src;

   // Every outstanding read holds a reserved slot, so a landing response always fits.
   assign occupancy = (PW+2)'(count) + (PW+2)'(inflight) - (PW+2)'(pop);
   assign imem_req  = ~rst & ~ex_mem_pc_src & (occupancy < (PW+2)'(DEPTH));
   assign imem_addr = pc;

   assign if_id_instr = if_id_valid ? q_instr[rd_ptr] : '0;
   assign if_id_npc   = if_id_valid ? q_npc[rd_ptr]   : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc           <= RESET_PC;
         tag_npc      <= '0;
         inflight     <= 1'b0;
         count        <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         redirect_cnt <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            pc      <= pc + AW'(4);
            tag_npc <= pc + AW'(4);
         end
         if (ex_mem_pc_src) begin
            pc     <= {ex_mem_npc[AW-1:2], 2'b00};
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            if (redirect_cnt != {CW{1'b1}})
               redirect_cnt <= redirect_cnt + CW'(1);
         end else begin
            if (push)
               wr_ptr <= wr_ptr + PW'(1);
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
         end
      end
   end

   // Payload storage needs no reset; the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         q_instr[wr_ptr] <= imem_rdata;
         q_npc[wr_ptr]   <= tag_npc;
      end
   end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: directed scenarios plus random ready/redirect
// traffic, checked against a queue-of-issued-fetches reference model.
module tb_fetch_queue_stage;

   localparam int unsigned   AW      = 32;
   localparam int unsigned   DW      = 32;
   localparam int unsigned   DEPTH   = 4;
   localparam int unsigned   CW      = 16;
   localparam logic [31:0]   WRAP_PC = 32'hFFFF_FFF8;

   logic          clk = 1'b0;
   logic          rst;
   logic          ex_mem_pc_src;
   logic [AW-1:0] ex_mem_npc;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_rdata;
   logic          if_id_valid;
   logic          if_id_ready;
   logic [DW-1:0] if_id_instr;
   logic [AW-1:0] if_id_npc;
   logic [CW-1:0] redirect_cnt;

   logic          imem_req_w;
   logic [AW-1:0] imem_addr_w;
   logic [DW-1:0] imem_rdata_w;
   logic          if_id_valid_w;
   logic [DW-1:0] if_id_instr_w;
   logic [AW-1:0] if_id_npc_w;
   logic [CW-1:0] redirect_cnt_w;

   always #5 clk = ~clk;

   fetch_queue_stage #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_PC('0), .CW(CW)) dut (
      .clk(clk), .rst(rst), .ex_mem_pc_src(ex_mem_pc_src), .ex_mem_npc(ex_mem_npc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .if_id_valid(if_id_valid), .if_id_ready(if_id_ready), .if_id_instr(if_id_instr),
      .if_id_npc(if_id_npc), .redirect_cnt(redirect_cnt));

   fetch_queue_stage #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_PC(WRAP_PC), .CW(CW)) dut_w (
      .clk(clk), .rst(rst), .ex_mem_pc_src(1'b0), .ex_mem_npc('0),
      .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
      .if_id_valid(if_id_valid_w), .if_id_ready(if_id_ready), .if_id_instr(if_id_instr_w),
      .if_id_npc(if_id_npc_w), .redirect_cnt(redirect_cnt_w));

   // Memory image: the word at byte address A holds A + 0x1000.
   always @(posedge clk) begin
      imem_rdata   <= imem_addr + 32'h1000;
      imem_rdata_w <= imem_addr_w + 32'h1000;
   end

   typedef struct {
      int          cyc;
      logic [31:0] addr;
   } fetch_t;

   fetch_t      q[$];
   logic [31:0] fetch_pc;
   logic [15:0] rcnt;
   int          cyc;
   int          n_issue;
   int          total = 0;
   int          bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      fetch_pc = 32'h0;
      rcnt     = '0;
      n_issue  = 0;
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance.
   task automatic step(input logic src, input logic [31:0] tgt, input logic rdy);
      logic        ev;
      logic        er;
      int          occ;
      logic [31:0] e_npc;
      logic [31:0] e_instr;
      fetch_t      f;
      ex_mem_pc_src = src;
      ex_mem_npc    = tgt;
      if_id_ready   = rdy;
      #1;
      ev  = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
      occ = q.size() - ((ev && rdy) ? 1 : 0);
      er  = !src && (occ < int'(DEPTH));
      chk("valid", if_id_valid, ev);
      if (ev) begin
         e_npc   = q[0].addr + 32'd4;
         e_instr = q[0].addr + 32'h1000;
         chk("head_npc", if_id_npc, e_npc);
         chk("head_instr", if_id_instr, e_instr);
      end
      chk("imem_req", imem_req, er);
      if (er) chk("imem_addr", imem_addr, fetch_pc);
      chk("redirect_cnt", redirect_cnt, rcnt);
      if (ev && rdy) void'(q.pop_front());
      if (src) begin
         q.delete();
         fetch_pc = {tgt[31:2], 2'b00};
         if (rcnt != 16'hFFFF) rcnt++;
      end else if (er) begin
         f.cyc  = cyc;
         f.addr = fetch_pc;
         q.push_back(f);
         fetch_pc = fetch_pc + 32'd4;
         n_issue++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_valid", if_id_valid, 1'b0);
      chk("rst_req", imem_req, 1'b0);
      chk("rst_instr", if_id_instr, 32'h0);
      chk("rst_npc", if_id_npc, 32'h0);
      chk("rst_cnt", redirect_cnt, 16'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin : main
      logic [31:0] wa;
      logic [15:0] cnt_before;
      rst           = 1'b1;
      ex_mem_pc_src = 1'b0;
      ex_mem_npc    = '0;
      if_id_ready   = 1'b1;
      cyc           = 0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Streaming from reset; the second instance exercises address wrap.
      for (int i = 0; i < 3; i++) begin
         #1;
         wa = WRAP_PC + 32'(4 * i);
         chk("wrap_req", imem_req_w, 1'b1);
         chk("wrap_addr", imem_addr_w, wa);
         step(1'b0, 32'h0, 1'b1);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

      // Mid-stream reset drops valid without a clock edge.
      #1;
      chk("pre_rst_valid", if_id_valid, 1'b1);
      do_reset();

      // Stall: exactly DEPTH fetches, head held.
      n_issue = 0;
      for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
      chk("stall_fetches", n_issue, DEPTH);
      chk("stall_req", imem_req, 1'b0);
      chk("stall_head_npc", if_id_npc, 32'h4);
      chk("stall_head_instr", if_id_instr, 32'h1000);
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

      // Redirect with queue half full and a read in flight.
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
      cnt_before = rcnt;
      step(1'b1, 32'h40, 1'b0);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      #1;
      chk("redir_valid_t3", if_id_valid, 1'b1);
      chk("redir_instr_t3", if_id_instr, 32'h1040);
      chk("redir_npc_t3", if_id_npc, 32'h44);
      chk("redir_cnt", redirect_cnt, 16'(cnt_before + 16'd1));
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

      // Unaligned target.
      step(1'b1, 32'h43, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

      // Back-to-back redirects.
      cnt_before = rcnt;
      step(1'b1, 32'h100, 1'b1);
      step(1'b1, 32'h200, 1'b1);
      step(1'b1, 32'h300, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      #1;
      chk("b2b_instr", if_id_instr, 32'h1300);
      chk("b2b_cnt", redirect_cnt, 16'(cnt_before + 16'd3));
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

      // Random traffic.
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 3) != 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Parametrised instruction-fetch stage for the 5-stage MIPS pipeline; successor to the single-latch IF stage.
- Drives a synchronous instruction memory and buffers fetched {npc, instr} pairs in a DEPTH-entry prefetch queue.
- Presents a valid/ready IF/ID interface so decode can stall without losing instructions.
- Handles EX/MEM redirects by flushing the queue and killing any in-flight read.

Parameters:
- AW, 32: PC/address width in bits.
- DW, 32: instruction width in bits.
- DEPTH, 4: prefetch queue entries; legal values are powers of 2, minimum 2.
- RESET_PC, 0: PC value loaded on reset; must be word-aligned.
- CW, 16: width of the redirect counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_mem_pc_src  in  1  redirect request; 1 = take ex_mem_npc.
- ex_mem_npc  in  AW  redirect target; bits [1:0] are ignored and forced to 0.
- imem_req  out  1  instruction memory read strobe.
- imem_addr  out  AW  byte address of the read; valid when imem_req = 1.
- imem_rdata  in  DW  read data, returned exactly 1 cycle after imem_req.
- if_id_valid  out  1  queue head holds a valid instruction.
- if_id_ready  in  1  decode accepts the head this cycle; 0 = stall.
- if_id_instr  out  DW  instruction at the queue head.
- if_id_npc  out  AW  PC+4 of the head instruction.
- redirect_cnt  out  CW  number of redirects taken; saturating.

Behaviour:
- Reset, asynchronous, active-high:
  - pc = RESET_PC; queue count = 0; read/write pointers = 0; inflight = 0.
  - redirect_cnt = 0; imem_req = 0; if_id_valid = 0.
  - if_id_instr and if_id_npc = 0.
  - Reset asserted mid-operation discards everything, including any in-flight read.
- pop = if_id_valid & if_id_ready. The head is removed at the clock edge; if_id_instr and if_id_npc hold steady while valid and not popped.
- Issue condition: imem_req = !ex_mem_pc_src & ((count + inflight - pop) < DEPTH). A slot is reserved for every outstanding read, so the queue never overflows.
- On issue:
  - imem_addr = pc.
  - pc <= pc + 4, wrapping modulo 2^AW.
  - inflight <= 1.
  - tag_npc <= pc + 4.
- With no issue, inflight <= 0 on the next edge; at most one read is outstanding.
- Response: in the cycle after an issue that was not killed, {tag_npc, imem_rdata} is written to the queue tail at the clock edge.
- Latency:
  - Request in cycle t.
  - Data written at the end of cycle t+1.
  - if_id_valid visible in cycle t+2.
- Sustained throughput is 1 instruction per cycle when if_id_ready = 1 continuously and DEPTH >= 2.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Redirect, when ex_mem_pc_src = 1 in cycle t:
  - Queue flushed (count = 0, pointers reset).
  - Any response arriving in cycle t is dropped.
  - inflight cleared; imem_req = 0 in cycle t.
  - pc <= {ex_mem_npc[AW-1:2], 2'b00}.
  - First request at the target in t+1; first valid output in t+3.
  - A pop in cycle t still completes: decode sees the handshake, and the entry is discarded with the flush.
  - Redirect takes priority over push and pop for the queue state.
- Back-to-back redirects: each one restarts fetch from its own target; there is no accumulation.
- redirect_cnt increments by 1 per cycle with ex_mem_pc_src = 1 and saturates at 2^CW-1.
- Full queue with if_id_ready = 0: imem_req stays 0, and pc and the queue contents hold indefinitely.

Test Plan:
- Reset release, memory word at address A = A + 0x1000, if_id_ready = 1:
  - imem_addr = 0, 4, 8 on consecutive cycles.
  - From cycle 2, one instruction per cycle: instr = 0x1000, 0x1004, 0x1008 with npc = 4, 8, 0xC.
- Stall: hold if_id_ready = 0 for 10 cycles with DEPTH = 4.
  - Exactly 4 entries are fetched; imem_req = 0 thereafter; the head stays instr 0x1000 / npc 4.
  - On release, entries drain in order with no loss or duplication.
- Redirect to 0x40 while the queue is half full and a read is in flight:
  - No stale entry appears.
  - The next valid output is instr 0x1040 / npc 0x44, three cycles after the redirect.
  - redirect_cnt = 1.
- Redirect to an unaligned target 0x43: fetch resumes at 0x40.
- Redirects asserted on 3 consecutive cycles to 0x100, 0x200, 0x300: the only output stream is 0x1300, 0x1304, …; redirect_cnt = 3.
- Wrap and mid-fetch reset:
  - With RESET_PC = 0xFFFFFFF8, the addresses issued are 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
  - Asserting rst mid-stream clears if_id_valid immediately, with no clock edge required.
